uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 upward, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // cand[k] is the requester examined at search position k.
  logic [IW-1:0] cand [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = IW'((int'(last_grant) + gi + 1) % N);
    end
  endgenerate

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[cand[k]]) begin
        any = 1'b1;
        idx = cand[k];
      end
    end
    if (any) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters with round-robin
// fairness, start/busy handshake and a bounded wait for the transmitter to respond.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16,
  localparam int IW          = idx_width(NUM_REQ),
  localparam int CW          = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [IW-1:0]             grant_id,
  output logic                      active,
  output logic                      err_timeout
);

  state_t state_reg, state_next;

  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [IW-1:0]        last_reg, last_next;
  logic [NUM_REQ-1:0]   req_ready_reg, req_ready_next;
  logic                 tx_start_reg, tx_start_next;
  logic [BYTE_W-1:0]    tx_data_reg, tx_data_next;
  logic [IW-1:0]        grant_reg, grant_next;
  logic                 active_reg, active_next;
  logic                 err_reg, err_next;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic                 accept;
  logic                 timed_out;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_reg),
    .grant      (arb_grant),
    .idx        (arb_idx),
    .any        (arb_any)
  );

  // A new frame is only accepted once the transmitter has gone quiet.
  assign accept    = (state_reg == IDLE) && arb_any && !tx_busy;
  assign timed_out = (state_reg == WAIT_BUSY) && !tx_busy &&
                     (cnt_reg == CW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      last_reg      <= IW'(NUM_REQ - 1);
      req_ready_reg <= '0;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= '0;
      grant_reg     <= '0;
      active_reg    <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      last_reg      <= last_next;
      req_ready_reg <= req_ready_next;
      tx_start_reg  <= tx_start_next;
      tx_data_reg   <= tx_data_next;
      grant_reg     <= grant_next;
      active_reg    <= active_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:      if (accept) state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timed_out) begin
          state_next = IDLE;
        end
      end
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_next = '0;
    tx_start_next  = 1'b0;
    err_next       = 1'b0;
    tx_data_next   = tx_data_reg;
    grant_next     = grant_reg;
    last_next      = last_reg;
    cnt_next       = cnt_reg;
    active_next    = (state_next != IDLE);
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          req_ready_next = arb_grant;
          tx_data_next   = req_data[int'(arb_idx)*BYTE_W +: BYTE_W];
          grant_next     = arb_idx;
          last_next      = arb_idx;
        end
      end
      START: begin
        tx_start_next = 1'b1;
        cnt_next      = '0;
      end
      WAIT_BUSY: begin
        // Saturating count keeps the counter from wrapping back into range.
        if (!tx_busy && cnt_reg != CW'(BUSY_TIMEOUT)) begin
          cnt_next = cnt_reg + CW'(1);
        end
        err_next = timed_out;
      end
      default: begin
      end
    endcase
  end

  assign req_ready   = req_ready_reg;
  assign tx_start    = tx_start_reg;
  assign tx_data     = tx_data_reg;
  assign grant_id    = grant_reg;
  assign active      = active_reg;
  assign err_timeout = err_reg;

endmodule
